// File: rtl/clk_div_prog_if.sv
// Control and output bundle for the programmable clock divider.
// The master drives enables and ratio writes; the slave (divider) returns clocks and ticks.
interface clk_div_prog_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
);
    localparam int WCH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                en;
    logic                sync;
    logic                wr_en;
    logic [WCH_W-1:0]    wr_ch;
    logic [CNT_W-1:0]    wr_half;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;

    modport master (
        output en, sync, wr_en, wr_ch, wr_half,
        input  clk_out, tick
    );

    modport slave (
        input  en, sync, wr_en, wr_ch, wr_half,
        output clk_out, tick
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider with registered 50% duty outputs and rise ticks.
// Ratio writes land in a shadow register and only reach the active ratio at a toggle boundary.
module clk_div_prog #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 5
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);
    localparam int               WCH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0]    cnt      [CHANNELS];
    logic [CNT_W-1:0]    act_half [CHANNELS];
    logic [CNT_W-1:0]    shd_half [CHANNELS];
    logic [CHANNELS-1:0] clk_q;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] wr_hit;

    // Out-of-range channel numbers simply match no channel, so the write is dropped.
    always_comb begin
        wr_hit = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            wr_hit[ch] = bus.wr_en && (bus.wr_ch == WCH_W'(ch));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_q  <= '0;
            tick_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt[ch]      <= '0;
                act_half[ch] <= RST_HALF;
                shd_half[ch] <= RST_HALF;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (wr_hit[ch]) begin
                    shd_half[ch] <= bus.wr_half;
                end

                if (bus.sync) begin
                    cnt[ch]      <= '0;
                    clk_q[ch]    <= 1'b0;
                    tick_q[ch]   <= 1'b0;
                    act_half[ch] <= wr_hit[ch] ? bus.wr_half : shd_half[ch];
                end else if (!bus.en) begin
                    tick_q[ch] <= 1'b0;
                end else if (act_half[ch] == '0) begin
                    // Stopped: hold the output level; a nonzero write restarts without waiting.
                    cnt[ch]    <= '0;
                    tick_q[ch] <= 1'b0;
                    if (wr_hit[ch] && (bus.wr_half != '0)) begin
                        act_half[ch] <= bus.wr_half;
                    end
                end else if (cnt[ch] == (act_half[ch] - ONE)) begin
                    cnt[ch]      <= '0;
                    clk_q[ch]    <= ~clk_q[ch];
                    tick_q[ch]   <= ~clk_q[ch];
                    act_half[ch] <= shd_half[ch];
                end else begin
                    cnt[ch]    <= cnt[ch] + ONE;
                    tick_q[ch] <= 1'b0;
                end
            end
        end
    end

    assign bus.clk_out = clk_q;
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a down-counting reference model queues expected
// outputs each cycle and they are compared one posedge later.
module tb_clk_div_prog;
    localparam int N     = 3;
    localparam int CNT_W = 8;
    localparam int WCH_W = 2;

    logic clk = 1'b0;
    logic rst;

    clk_div_prog_if #(.CHANNELS(N), .CNT_W(CNT_W)) bus ();

    clk_div_prog #(.CHANNELS(N), .CNT_W(CNT_W), .DEFAULT_HALF(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ticks0 = 0;

    logic [2*N-1:0]   exp_q[$];
    logic [N-1:0]     m_lvl;
    logic [N-1:0]     m_tk;
    logic [CNT_W-1:0] m_act [N];
    logic [CNT_W-1:0] m_shd [N];
    logic [CNT_W-1:0] m_rem [N];

    // Model tracks cycles remaining until the next toggle rather than an up-counter.
    task automatic model_step();
        logic             hit;
        logic [CNT_W-1:0] old_shd;
        for (int ch = 0; ch < N; ch++) begin
            if (rst) begin
                m_lvl[ch] = 1'b0;
                m_tk[ch]  = 1'b0;
                m_act[ch] = 8'd5;
                m_shd[ch] = 8'd5;
                m_rem[ch] = 8'd5;
            end else begin
                hit     = bus.wr_en && (int'(bus.wr_ch) == ch);
                old_shd = m_shd[ch];
                if (hit) m_shd[ch] = bus.wr_half;
                if (bus.sync) begin
                    m_lvl[ch] = 1'b0;
                    m_tk[ch]  = 1'b0;
                    m_act[ch] = m_shd[ch];
                    m_rem[ch] = m_shd[ch];
                end else if (!bus.en) begin
                    m_tk[ch] = 1'b0;
                end else if (m_act[ch] == 0) begin
                    m_tk[ch] = 1'b0;
                    if (hit && bus.wr_half != 0) begin
                        m_act[ch] = bus.wr_half;
                        m_rem[ch] = bus.wr_half;
                    end
                end else if (m_rem[ch] == 1) begin
                    m_tk[ch]  = !m_lvl[ch];
                    m_lvl[ch] = !m_lvl[ch];
                    m_act[ch] = old_shd;
                    m_rem[ch] = old_shd;
                end else begin
                    m_tk[ch]  = 1'b0;
                    m_rem[ch] = m_rem[ch] - 1;
                end
            end
        end
        exp_q.push_back({m_lvl, m_tk});
    endtask

    task automatic check_output(input string tag);
        logic [2*N-1:0] exp_v;
        exp_v = exp_q.pop_front();
        checks++;
        assert (bus.clk_out === exp_v[2*N-1:N]) else begin
            errors++;
            $error("[TB] FAIL %s clk_out observed=%b expected=%b", tag, bus.clk_out, exp_v[2*N-1:N]);
        end
        checks++;
        assert (bus.tick === exp_v[N-1:0]) else begin
            errors++;
            $error("[TB] FAIL %s tick observed=%b expected=%b", tag, bus.tick, exp_v[N-1:0]);
        end
        if (bus.tick[0] === 1'b1) ticks0++;
    endtask

    task automatic apply_stimulus(input string tag, input logic r, input logic e, input logic s,
                                  input logic we, input logic [WCH_W-1:0] wc,
                                  input logic [CNT_W-1:0] wh, input int cycles);
        rst         = r;
        bus.en      = e;
        bus.sync    = s;
        bus.wr_en   = we;
        bus.wr_ch   = wc;
        bus.wr_half = wh;
        for (int i = 0; i < cycles; i++) begin
            model_step();
            @(posedge clk);
            #1;
            check_output(tag);
        end
    endtask

    initial begin
        $display("[TB] clk_div_prog directed run starting");
        apply_stimulus("reset",      1, 0, 0, 0, 0, 0, 2);

        ticks0 = 0;
        apply_stimulus("div10",      0, 1, 0, 0, 0, 0, 40);
        checks++;
        assert (ticks0 === 4) else begin
            errors++;
            $error("[TB] FAIL div10_tick_count observed=%0d expected=%0d", ticks0, 4);
        end

        apply_stimulus("pre_wr1",    0, 1, 0, 0, 0, 0, 7);
        apply_stimulus("wr1_half3",  0, 1, 0, 1, 1, 8'd3, 1);
        apply_stimulus("run_half3",  0, 1, 0, 0, 0, 0, 30);

        apply_stimulus("wr0_stop",   0, 1, 0, 1, 0, 8'd0, 1);
        apply_stimulus("stopping",   0, 1, 0, 0, 0, 0, 25);
        apply_stimulus("wr0_half2",  0, 1, 0, 1, 0, 8'd2, 1);
        apply_stimulus("run_half2",  0, 1, 0, 0, 0, 0, 15);

        apply_stimulus("pre_freeze", 0, 1, 0, 0, 0, 0, 3);
        apply_stimulus("freeze",     0, 0, 0, 0, 0, 0, 7);
        apply_stimulus("resume",     0, 1, 0, 0, 0, 0, 12);

        apply_stimulus("sync_wr1",   0, 1, 1, 1, 1, 8'd4, 1);
        apply_stimulus("post_sync",  0, 1, 0, 0, 0, 0, 20);

        apply_stimulus("wr_oor",     0, 1, 0, 1, 2'd3, 8'd1, 1);
        apply_stimulus("post_oor",   0, 1, 0, 0, 0, 0, 1);
        apply_stimulus("mid_reset",  1, 1, 0, 0, 0, 0, 1);
        apply_stimulus("after_rst",  0, 1, 0, 0, 0, 0, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
